// File: rtl/fcs_pkg.sv
// Shared definitions for the 802.15.4 CRC-16 generator/checker pair.
// One serial CRC step is exposed here so both directions compute it identically.
package fcs_pkg;

    localparam logic [15:0] CRC_POLY = 16'h8408;
    localparam logic [15:0] CRC_INIT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MHR  = 2'd1,
        FCS  = 2'd2,
        DONE = 2'd3
    } fcs_chk_state_t;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        data_bit,
                                               input logic [15:0] poly = CRC_POLY);
        logic fb;
        fb = data_bit ^ crc[0];
        return (crc >> 1) ^ (fb ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/fcs_16bit_checker_if.sv
// Bit-stream input and verdict output bundle of the FCS checker.
// master = PHY/MAC side driving bits, slave = the checker.
interface fcs_16bit_checker_if;

    logic        start;
    logic [6:0]  frame_len;
    logic        data;
    logic        data_valid;
    logic        busy;
    logic        done;
    logic        fcs_ok;
    logic        fcs_err;
    logic        len_err;
    logic [15:0] fcs_calc;
    logic [15:0] fcs_rx;

    modport master (
        output start, frame_len, data, data_valid,
        input  busy, done, fcs_ok, fcs_err, len_err, fcs_calc, fcs_rx
    );

    modport slave (
        input  start, frame_len, data, data_valid,
        output busy, done, fcs_ok, fcs_err, len_err, fcs_calc, fcs_rx
    );

endinterface

// File: rtl/crc16_serial_core.sv
// Bit-serial reflected CRC-16 register; clear has priority over enable.
// Kept standalone so the FCS generator can reuse it unchanged.
module crc16_serial_core #(
    parameter logic [15:0] POLY = fcs_pkg::CRC_POLY,
    parameter logic [15:0] INIT = fcs_pkg::CRC_INIT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        data_bit,
    output logic [15:0] crc
);
    import fcs_pkg::*;

    always_ff @(posedge clock) begin
        if (reset) begin
            crc <= INIT;
        end else if (clear) begin
            crc <= INIT;
        end else if (enable) begin
            crc <= crc16_step(crc, data_bit, POLY);
        end
    end

endmodule

// File: rtl/fcs_16bit_checker.sv
// Receive-side 802.15.4 FCS checker: CRC over the MHR bits, capture of the
// trailing 16 FCS bits, and a one-cycle verdict pulse after the last bit.
//
//   state | meaning
//   IDLE  | no frame open; waiting for start
//   MHR   | accepting MHR/payload bits, CRC running
//   FCS   | capturing received FCS bits, CRC frozen
//   DONE  | one cycle; verdict registered on leaving
module fcs_16bit_checker #(
    parameter int          MAX_LEN  = 127,
    parameter logic [15:0] CRC_POLY = fcs_pkg::CRC_POLY,
    parameter logic [15:0] CRC_INIT = fcs_pkg::CRC_INIT
) (
    input logic                clock,
    input logic                reset,
    fcs_16bit_checker_if.slave bus
);
    import fcs_pkg::*;

    fcs_chk_state_t state;
    logic [9:0]     bit_cnt;
    logic [9:0]     mhr_bits;
    logic [15:0]    fcs_rx_q;
    logic [15:0]    crc;
    logic           done_q;
    logic           ok_q;
    logic           err_q;
    logic           len_err_q;
    logic           len_ok;
    logic           accept_mhr;
    logic           last_mhr;

    assign len_ok     = (int'(bus.frame_len) >= 2) && (int'(bus.frame_len) <= MAX_LEN);
    assign accept_mhr = (state == MHR) && bus.data_valid && !bus.start;
    assign last_mhr   = (bit_cnt == mhr_bits - 10'd1);

    crc16_serial_core #(
        .POLY (CRC_POLY),
        .INIT (CRC_INIT)
    ) u_crc (
        .clock    (clock),
        .reset    (reset),
        .clear    (bus.start && len_ok),
        .enable   (accept_mhr),
        .data_bit (bus.data),
        .crc      (crc)
    );

    // start is honoured in every state, which is what gives abort/restart.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            mhr_bits  <= '0;
            fcs_rx_q  <= '0;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                if (len_ok) begin
                    state     <= (bus.frame_len == 7'd2) ? FCS : MHR;
                    bit_cnt   <= '0;
                    mhr_bits  <= {bus.frame_len - 7'd2, 3'b000};
                    fcs_rx_q  <= '0;
                    ok_q      <= 1'b0;
                    err_q     <= 1'b0;
                    len_err_q <= 1'b0;
                end else begin
                    state     <= IDLE;
                    done_q    <= 1'b1;
                    ok_q      <= 1'b0;
                    err_q     <= 1'b1;
                    len_err_q <= 1'b1;
                end
            end else begin
                case (state)
                    MHR: begin
                        if (bus.data_valid) begin
                            if (last_mhr) begin
                                state   <= FCS;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 10'd1;
                            end
                        end
                    end
                    FCS: begin
                        if (bus.data_valid) begin
                            fcs_rx_q[bit_cnt[3:0]] <= bus.data;
                            if (bit_cnt == 10'd15) begin
                                state <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 10'd1;
                            end
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                        ok_q   <= (fcs_rx_q == crc);
                        err_q  <= (fcs_rx_q != crc);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy     = (state == MHR) || (state == FCS);
    assign bus.done     = done_q;
    assign bus.fcs_ok   = ok_q;
    assign bus.fcs_err  = err_q;
    assign bus.len_err  = len_err_q;
    assign bus.fcs_calc = crc;
    assign bus.fcs_rx   = fcs_rx_q;

endmodule

// File: tb/tb_fcs_16bit_checker.sv
// Directed bench for fcs_16bit_checker: frame-level reference model compared
// every cycle, plus literal expectations for the documented frames.
module tb_fcs_16bit_checker;

    localparam logic [15:0] POLY = 16'h8408;
    localparam logic [15:0] INIT = 16'h0000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fcs_16bit_checker_if bus();

    fcs_16bit_checker dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;

    // reference model state (frame-level view)
    logic        m_bits[$];
    int          m_need;
    int          m_fcnt;
    logic        m_open, m_pend, m_done, m_ok, m_err, m_len;
    logic [15:0] m_rx, m_calc;

    function automatic logic [15:0] crc_of_bits(input logic q[$]);
        logic [15:0] c;
        c = INIT;
        foreach (q[i]) c = (c >> 1) ^ ((q[i] ^ c[0]) ? POLY : 16'h0000);
        return c;
    endfunction

    function automatic logic [15:0] crc_of_bytes(input logic [7:0] b[$]);
        logic [15:0] c;
        c = INIT;
        foreach (b[i]) begin
            c = c ^ {8'h00, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_open = 0; m_pend = 0; m_done = 0; m_ok = 0; m_err = 0; m_len = 0;
            m_rx = '0; m_calc = INIT; m_need = 0; m_fcnt = 0; m_bits.delete();
        end else begin
            m_done = 0;
            if (bus.start) begin
                m_pend = 0;
                if (int'(bus.frame_len) >= 2 && int'(bus.frame_len) <= 127) begin
                    m_open = 1; m_need = (int'(bus.frame_len) - 2) * 8; m_fcnt = 0;
                    m_bits.delete(); m_calc = INIT; m_rx = '0;
                    m_ok = 0; m_err = 0; m_len = 0;
                end else begin
                    m_open = 0; m_done = 1; m_ok = 0; m_err = 1; m_len = 1;
                end
            end else if (m_pend) begin
                m_pend = 0; m_done = 1; m_ok = (m_rx == m_calc); m_err = !m_ok;
            end else if (m_open && bus.data_valid) begin
                if (m_bits.size() < m_need) begin
                    m_bits.push_back(bus.data);
                    m_calc = crc_of_bits(m_bits);
                end else begin
                    m_rx[m_fcnt] = bus.data;
                    m_fcnt++;
                    if (m_fcnt == 16) begin m_open = 0; m_pend = 1; end
                end
            end
        end
    end

    logic [36:0] act_v, exp_v;
    always @(negedge clock) begin
        if (bus.done === 1'b1) done_cnt++;
        if (chk_en) begin
            act_v = {bus.busy, bus.done, bus.fcs_ok, bus.fcs_err, bus.len_err, bus.fcs_calc, bus.fcs_rx};
            exp_v = {m_open, m_done, m_ok, m_err, m_len, m_calc, m_rx};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_model t=%0t actual{busy,done,ok,err,len,calc,rx}=%h required=%h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [6:0] len);
        bus.start      = 1'b1;
        bus.frame_len  = len;
        bus.data_valid = 1'b1;
        bus.data       = 1'($urandom_range(0, 1));
        tick();
        bus.start      = 1'b0;
        bus.data_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit stall);
        int n;
        n = stall ? int'($urandom_range(0, 2)) : 0;
        repeat (n) begin
            bus.data_valid = 1'b0;
            bus.data       = 1'($urandom_range(0, 1));
            tick();
        end
        bus.data_valid = 1'b1;
        bus.data       = b;
        tick();
        bus.data_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [6:0] len, input logic [23:0] mhr, input int nbytes,
                              input logic [15:0] fcs, input int flip, input bit stall);
        logic b;
        do_start(len);
        for (int i = 0; i < nbytes * 8; i++) begin
            b = mhr[i];
            if (i == flip) b = ~b;
            send_bit(b, stall);
        end
        for (int k = 0; k < 16; k++) send_bit(fcs[k], stall);
    endtask

    // Leaves the bench on the negedge where done is high, or reports a timeout.
    task automatic wait_done(input string name, input int exp_lat);
        int n;
        bit found;
        n = 0;
        found = 0;
        while (n < 20 && !found) begin
            @(negedge clock);
            if (bus.done === 1'b1) found = 1;
            else n++;
        end
        if (!found) begin
            failures++;
            checks++;
            $display("FAIL %s_timeout actual=no_done required=done_within_20", name);
        end else begin
            checki({name, "_latency"}, n, exp_lat);
        end
    endtask

    task automatic realign();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] pin_bytes[$];
        logic       empty_q[$];
        int         base;

        reset = 1'b1;
        bus.start = 1'b0; bus.frame_len = '0; bus.data = 1'b0; bus.data_valid = 1'b0;
        chk_en = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        check1("reset_busy", bus.busy, 1'b0);
        check1("reset_done", bus.done, 1'b0);
        check1("reset_ok", bus.fcs_ok, 1'b0);
        check1("reset_err", bus.fcs_err, 1'b0);
        check1("reset_len_err", bus.len_err, 1'b0);
        check16("reset_calc", bus.fcs_calc, 16'h0000);
        check16("reset_rx", bus.fcs_rx, 16'h0000);
        realign();

        pin_bytes = '{8'h02, 8'h00, 8'h6A};
        check16("model_crc_bytes", crc_of_bytes(pin_bytes), 16'h79E4);
        check16("model_crc_empty", crc_of_bits(empty_q), 16'h0000);

        send_frame(7'd5, 24'h6A0002, 3, 16'h79E4, -1, 1'b0);
        wait_done("good", 1);
        check1("good_ok", bus.fcs_ok, 1'b1);
        check1("good_err", bus.fcs_err, 1'b0);
        check16("good_calc", bus.fcs_calc, 16'h79E4);
        check16("good_rx", bus.fcs_rx, 16'h79E4);
        realign();

        send_frame(7'd5, 24'h6A0002, 3, 16'h79E4, 5, 1'b0);
        wait_done("corrupt", 1);
        check1("corrupt_ok", bus.fcs_ok, 1'b0);
        check1("corrupt_err", bus.fcs_err, 1'b1);
        check16("corrupt_rx", bus.fcs_rx, 16'h79E4);
        realign();

        send_frame(7'd5, 24'h6A0002, 3, 16'h79E4, -1, 1'b1);
        wait_done("stall", 1);
        check1("stall_ok", bus.fcs_ok, 1'b1);
        check16("stall_calc", bus.fcs_calc, 16'h79E4);
        realign();

        do_start(7'd1);
        wait_done("len1", 0);
        check1("len1_len_err", bus.len_err, 1'b1);
        check1("len1_err", bus.fcs_err, 1'b1);
        check1("len1_ok", bus.fcs_ok, 1'b0);
        check1("len1_busy", bus.busy, 1'b0);
        realign();

        do_start(7'd0);
        wait_done("len0", 0);
        check1("len0_len_err", bus.len_err, 1'b1);
        check1("len0_err", bus.fcs_err, 1'b1);
        realign();

        send_frame(7'd2, 24'h0, 0, 16'h0000, -1, 1'b0);
        wait_done("empty_good", 1);
        check1("empty_good_ok", bus.fcs_ok, 1'b1);
        check16("empty_calc", bus.fcs_calc, 16'h0000);
        realign();

        send_frame(7'd2, 24'h0, 0, 16'h0001, -1, 1'b0);
        wait_done("empty_bad", 1);
        check1("empty_bad_err", bus.fcs_err, 1'b1);
        check16("empty_bad_rx", bus.fcs_rx, 16'h0001);
        realign();

        base = done_cnt;
        do_start(7'd5);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        send_frame(7'd5, 24'h6A0002, 3, 16'h79E4, -1, 1'b0);
        wait_done("abort", 1);
        check1("abort_ok", bus.fcs_ok, 1'b1);
        repeat (5) tick();
        checki("abort_done_count", done_cnt - base, 1);

        base = done_cnt;
        do_start(7'd5);
        for (int i = 0; i < 24; i++) send_bit(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check1("rst_mid_busy", bus.busy, 1'b0);
        check1("rst_mid_done", bus.done, 1'b0);
        check16("rst_mid_calc", bus.fcs_calc, 16'h0000);
        check16("rst_mid_rx", bus.fcs_rx, 16'h0000);
        repeat (20) tick();
        checki("rst_mid_done_count", done_cnt - base, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
